br_resolve_unit: RTL and testbench
==================================

Name: br_resolve_unit

Overview:
- Resolution/training counterpart to the branch predictor.
- Fetch enqueues each predicted branch (pc, predicted direction, predicted target) and gets a tag back.
- Execute resolves entries by tag, possibly out of order.
- Entries retire in program order:
  - every retired branch produces one training update (br_result, pc_result) for the predictor;
  - a mispredicted branch also produces a one-cycle flush and a redirect PC.

Parameters:
DEPTH, 8, number of in-flight branch entries; power of two, >= 2
TAG_W, $clog2(DEPTH), tag width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pred_valid  input  1  fetch presents a predicted branch
pred_pc  input  32  branch instruction PC
pred_taken  input  1  predicted direction
pred_addr  input  32  predicted next PC
pred_ready  output  1  entry available; enqueue occurs when pred_valid && pred_ready
pred_tag  output  TAG_W  tag assigned to the current enqueue (tail index)
res_valid  input  1  execute resolves a branch
res_tag  input  TAG_W  tag being resolved
res_taken  input  1  actual direction
res_target  input  32  actual taken target
upd_valid  output  1  one-cycle pulse: training update valid
upd_pc  output  32  PC of retired branch
br_result  output  1  actual direction of retired branch
pc_result  output  32  actual next PC of retired branch
flush  output  1  one-cycle pulse: discard younger work
redirect_pc  output  32  correct fetch PC, valid while flush=1
count  output  TAG_W+1  occupied entries

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Storage is a circular buffer of DEPTH entries with head and tail pointers (TAG_W bits, wrap modulo DEPTH) and an occupancy counter.
- Each entry holds: valid, resolved, pc, ptaken, paddr, ataken, atarget.
- Reset, including mid-operation:
  - head = tail = count = 0 and all valid/resolved bits cleared;
  - upd_valid, br_result, flush = 0; upd_pc, pc_result, redirect_pc = 0;
  - pred_ready = 0 while rst is high; state = RUN.
- pred_ready = (state == RUN) && (count != DEPTH). No bypass: when full, a same-cycle retire does not free the slot for that cycle's enqueue.
- Enqueue (RUN only):
  - write the tail entry (valid=1, resolved=0) and increment tail;
  - pred_tag = tail combinationally.
- Resolve (RUN only):
  - if entry[res_tag] is valid and not yet resolved, write ataken/atarget and set resolved;
  - otherwise ignore, with no state change.
  - A resolve may target the tail being enqueued in the same cycle; it is ignored, because the entry is not yet valid.
- Retire (RUN only):
  - at most one per cycle; condition is entry[head].valid && entry[head].resolved, using registered bits;
  - a resolve of the head therefore retires no earlier than the following cycle;
  - on retire, clear the head entry and increment head.
- Retire outputs, registered and visible the cycle after the retire edge, with upd_valid held high for exactly one cycle:
  - upd_pc = pc;
  - br_result = ataken;
  - pc_result = ataken ? atarget : pc + 4 (32-bit, wraps).
- Mispredict condition: (ataken != ptaken) || (ataken && atarget != paddr).
- FSM with two states, RUN and FLUSH:
  - RUN -> FLUSH on a retire that mispredicts. On that same edge:
    - emit the update;
    - drive flush = 1 and redirect_pc = pc_result;
    - clear all entries, set tail = head (count = 0);
    - a same-cycle enqueue or resolve is discarded.
  - FLUSH: flush stays 1 for this single cycle; pred_ready = 0; res_valid ignored; no retire.
  - FLUSH -> RUN unconditionally; flush returns to 0.
- count:
  - +1 on enqueue only; -1 on retire only; unchanged on simultaneous enqueue and retire;
  - forced to 0 on mispredict.
- Outside FLUSH, redirect_pc holds its last value; it is meaningful only while flush = 1.

Test Plan:
- Reset then enqueue pc=0x100, pred_taken=1, pred_addr=0x200 (tag 0); resolve tag 0 taken, 0x200 -> upd_valid pulses, upd_pc=0x100, br_result=1, pc_result=0x200, flush stays 0, count returns 0.
- Enqueue tags 0,1,2 (pc 0x10, 0x20, 0x30, all predicted not-taken); resolve order 2,0,1, all not-taken -> three updates in pc order 0x10, 0x20, 0x30 with pc_result = pc+4; no flush.
- Enqueue 0x40 (pred not-taken), then 0x50; resolve 0x40 taken to 0x80 -> flush=1 for one cycle, redirect_pc=0x80, pc_result=0x80, count=0; a resolve of 0x50's tag during FLUSH is ignored; pred_ready returns to 1 the next cycle.
- Target mismatch: pred taken to 0x300, actual taken to 0x304 -> flush with redirect_pc=0x304.
- Fill DEPTH=8 entries -> pred_ready=0 at count=8; a further pred_valid is not enqueued; retire the head -> pred_ready=1 next cycle; 9th enqueue gets tag 0 (wrap).
- Assert rst with 5 entries outstanding and a pending mispredict -> next cycle count=0, flush=0, upd_valid=0; an old tag resolved after reset produces no update.

Source files
------------

// File: rtl/br_resolve_unit.sv
// br_resolve_unit
//   Resolution/training companion to the branch predictor. Fetch enqueues each
//   predicted branch and receives a tag. Execute resolves entries by tag in any
//   order. Entries retire strictly in program order. Every retire produces one
//   registered training update. A mispredicted retire also produces a one-cycle
//   flush with the correct redirect PC, and it discards all younger entries.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pred_valid/pc/taken/addr fetch-side enqueue of a predicted branch
//   pred_ready, pred_tag     enqueue accepted when pred_valid && pred_ready; tag = tail
//   res_valid/tag/taken/target  execute-side resolution of an in-flight entry
//   upd_valid, upd_pc, br_result, pc_result  registered training update (1-cycle pulse)
//   flush, redirect_pc       registered 1-cycle flush and correct fetch PC
//   count                    number of occupied entries
module br_resolve_unit #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_addr,
  output logic             pred_ready,
  output logic [TAG_W-1:0] pred_tag,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             br_result,
  output logic [31:0]      pc_result,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [TAG_W:0]   count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W + 1)'(DEPTH);

  // A retired branch mispredicted if the direction differs, or if it was
  // taken to a different target than predicted.
  function automatic logic is_mispredict(input logic        ptaken,
                                         input logic [31:0] paddr,
                                         input logic        ataken,
                                         input logic [31:0] atarget);
    return (ataken != ptaken) || (ataken && (atarget != paddr));
  endfunction

  // Actual next PC of a resolved branch.
  function automatic logic [31:0] next_pc(input logic        ataken,
                                          input logic [31:0] atarget,
                                          input logic [31:0] pc);
    return ataken ? atarget : (pc + 32'd4);
  endfunction

  state_t           state_q;
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic             valid_q    [DEPTH];
  logic             resolved_q [DEPTH];
  logic [31:0]      pc_q       [DEPTH];
  logic             ptaken_q   [DEPTH];
  logic [31:0]      paddr_q    [DEPTH];
  logic             ataken_q   [DEPTH];
  logic [31:0]      atarget_q  [DEPTH];

  logic             upd_valid_q;
  logic [31:0]      upd_pc_q;
  logic             br_result_q;
  logic [31:0]      pc_result_q;
  logic             flush_q;
  logic [31:0]      redirect_q;

  logic             in_run_s;
  logic             ready_s;
  logic             do_enq_s;
  logic             do_res_s;
  logic             do_ret_s;
  logic             ret_misp_s;
  logic [31:0]      ret_npc_s;
  logic [TAG_W-1:0] head_nxt_s;

  // Handshake and per-cycle enqueue/resolve/retire decisions from registered state.
  always_comb begin
    in_run_s   = (state_q == RUN);
    // No bypass: a full buffer stays not-ready even if the head retires this cycle.
    ready_s    = in_run_s && !rst && (count_q != CNT_FULL);
    do_enq_s   = pred_valid && ready_s;
    // Entry bits are registered, so a resolve aimed at the slot being enqueued is ignored.
    do_res_s   = in_run_s && res_valid && valid_q[res_tag] && !resolved_q[res_tag];
    do_ret_s   = in_run_s && valid_q[head_q] && resolved_q[head_q];
    ret_npc_s  = next_pc(ataken_q[head_q], atarget_q[head_q], pc_q[head_q]);
    ret_misp_s = do_ret_s && is_mispredict(ptaken_q[head_q], paddr_q[head_q],
                                           ataken_q[head_q], atarget_q[head_q]);
    head_nxt_s = head_q + TAG_ONE;
  end

  // Buffer, pointers, FSM and registered update/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]    <= 1'b0;
        resolved_q[i] <= 1'b0;
      end
      upd_valid_q <= 1'b0;
      upd_pc_q    <= 32'd0;
      br_result_q <= 1'b0;
      pc_result_q <= 32'd0;
      flush_q     <= 1'b0;
      redirect_q  <= 32'd0;
    end else begin
      upd_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      case (state_q)
        RUN: begin
          if (do_ret_s) begin
            upd_valid_q        <= 1'b1;
            upd_pc_q           <= pc_q[head_q];
            br_result_q        <= ataken_q[head_q];
            pc_result_q        <= ret_npc_s;
            valid_q[head_q]    <= 1'b0;
            resolved_q[head_q] <= 1'b0;
            head_q             <= head_nxt_s;
          end
          if (ret_misp_s) begin
            // Everything younger than the mispredicted branch is wrong-path work.
            for (int i = 0; i < DEPTH; i++) begin
              valid_q[i]    <= 1'b0;
              resolved_q[i] <= 1'b0;
            end
            tail_q     <= head_nxt_s;
            count_q    <= '0;
            flush_q    <= 1'b1;
            redirect_q <= ret_npc_s;
            state_q    <= FLUSH;
          end else begin
            if (do_enq_s) begin
              valid_q[tail_q]    <= 1'b1;
              resolved_q[tail_q] <= 1'b0;
              pc_q[tail_q]       <= pred_pc;
              ptaken_q[tail_q]   <= pred_taken;
              paddr_q[tail_q]    <= pred_addr;
              tail_q             <= tail_q + TAG_ONE;
            end
            if (do_res_s) begin
              resolved_q[res_tag] <= 1'b1;
              ataken_q[res_tag]   <= res_taken;
              atarget_q[res_tag]  <= res_target;
            end
            if (do_enq_s && !do_ret_s) begin
              count_q <= count_q + CNT_ONE;
            end else if (!do_enq_s && do_ret_s) begin
              count_q <= count_q - CNT_ONE;
            end
          end
        end
        FLUSH: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pred_ready  = ready_s;
  assign pred_tag    = tail_q;
  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign br_result   = br_result_q;
  assign pc_result   = pc_result_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign count       = count_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed self-checking bench for br_resolve_unit (DEPTH = 8).
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, combinational handshake just before it.
module tb_br_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_addr;
  logic        pred_ready;
  logic [2:0]  pred_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        br_result;
  logic [31:0] pc_result;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  // ready/tag observed just before the most recent rising edge
  logic       ready_seen;
  logic [2:0] tag_seen;

  br_resolve_unit #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_addr(pred_addr), .pred_ready(pred_ready), .pred_tag(pred_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .br_result(br_result),
    .pc_result(pc_result), .flush(flush), .redirect_pc(redirect_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 unit after the rising edge.
  task automatic cyc(input logic r,
                     input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] pa,
                     input logic rv, input logic [2:0] rtg, input logic rtk, input logic [31:0] rtgt);
    @(negedge clk);
    rst = r; pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_addr = pa;
    res_valid = rv; res_tag = rtg; res_taken = rtk; res_target = rtgt;
    #1;
    ready_seen = pred_ready;
    tag_seen   = pred_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] pa);
    cyc(1'b0, 1'b1, pc, pt, pa, 1'b0, 3'd0, 1'b0, 32'd0);
  endtask

  task automatic res(input logic [2:0] tg, input logic tk, input logic [31:0] tgt);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, tg, tk, tgt);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0);
  endtask

  task automatic exp_upd(input string tag, input logic [31:0] pc, input logic br, input logic [31:0] pcr);
    check_val({tag, "_upd_valid"}, {31'd0, upd_valid}, 32'd1);
    check_val({tag, "_upd_pc"}, upd_pc, pc);
    check_val({tag, "_br_result"}, {31'd0, br_result}, {31'd0, br});
    check_val({tag, "_pc_result"}, pc_result, pcr);
  endtask

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_pc = 32'd0; pred_taken = 1'b0; pred_addr = 32'd0;
    res_valid = 1'b0; res_tag = 3'd0; res_taken = 1'b0; res_target = 32'd0;

    // ---- reset state ----
    do_reset();
    check_val("rst_ready", {31'd0, ready_seen}, 32'd0);
    check_val("rst_count", {28'd0, count}, 32'd0);
    check_val("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    check_val("rst_flush", {31'd0, flush}, 32'd0);
    check_val("rst_upd_pc", upd_pc, 32'd0);
    check_val("rst_pc_result", pc_result, 32'd0);
    check_val("rst_redirect", redirect_pc, 32'd0);

    // ---- single correctly predicted taken branch ----
    enq(32'h100, 1'b1, 32'h200);
    check_val("t1_ready", {31'd0, ready_seen}, 32'd1);
    check_val("t1_tag", {29'd0, tag_seen}, 32'd0);
    check_val("t1_count1", {28'd0, count}, 32'd1);
    res(3'd0, 1'b1, 32'h200);
    check_val("t1_no_early_upd", {31'd0, upd_valid}, 32'd0);
    idle();
    exp_upd("t1", 32'h100, 1'b1, 32'h200);
    check_val("t1_flush", {31'd0, flush}, 32'd0);
    check_val("t1_count0", {28'd0, count}, 32'd0);
    idle();
    check_val("t1_pulse", {31'd0, upd_valid}, 32'd0);

    // ---- out-of-order resolve, in-order retire ----
    do_reset();
    enq(32'h10, 1'b0, 32'h14);
    check_val("t2_tag0", {29'd0, tag_seen}, 32'd0);
    enq(32'h20, 1'b0, 32'h24);
    check_val("t2_tag1", {29'd0, tag_seen}, 32'd1);
    enq(32'h30, 1'b0, 32'h34);
    check_val("t2_tag2", {29'd0, tag_seen}, 32'd2);
    res(3'd2, 1'b0, 32'h0);
    check_val("t2_wait_head", {31'd0, upd_valid}, 32'd0);
    res(3'd0, 1'b0, 32'h0);
    check_val("t2_wait_head2", {31'd0, upd_valid}, 32'd0);
    res(3'd1, 1'b0, 32'h0);
    exp_upd("t2a", 32'h10, 1'b0, 32'h14);
    idle();
    exp_upd("t2b", 32'h20, 1'b0, 32'h24);
    idle();
    exp_upd("t2c", 32'h30, 1'b0, 32'h34);
    check_val("t2_flush", {31'd0, flush}, 32'd0);
    check_val("t2_count", {28'd0, count}, 32'd0);

    // ---- direction mispredict with flush ----
    do_reset();
    enq(32'h40, 1'b0, 32'h44);
    enq(32'h50, 1'b0, 32'h54);
    res(3'd0, 1'b1, 32'h80);
    idle();
    exp_upd("t3", 32'h40, 1'b1, 32'h80);
    check_val("t3_flush", {31'd0, flush}, 32'd1);
    check_val("t3_redirect", redirect_pc, 32'h80);
    check_val("t3_count", {28'd0, count}, 32'd0);
    res(3'd1, 1'b0, 32'h0);
    check_val("t3_flush_ready", {31'd0, ready_seen}, 32'd0);
    check_val("t3_flush_off", {31'd0, flush}, 32'd0);
    check_val("t3_no_upd", {31'd0, upd_valid}, 32'd0);
    idle();
    check_val("t3_ready_back", {31'd0, ready_seen}, 32'd1);
    check_val("t3_new_tag", {29'd0, tag_seen}, 32'd1);
    check_val("t3_no_upd2", {31'd0, upd_valid}, 32'd0);
    check_val("t3_count2", {28'd0, count}, 32'd0);

    // ---- target mispredict ----
    do_reset();
    enq(32'h60, 1'b1, 32'h300);
    res(3'd0, 1'b1, 32'h304);
    idle();
    exp_upd("t4", 32'h60, 1'b1, 32'h304);
    check_val("t4_flush", {31'd0, flush}, 32'd1);
    check_val("t4_redirect", redirect_pc, 32'h304);
    idle();
    check_val("t4_flush_off", {31'd0, flush}, 32'd0);
    check_val("t4_redirect_hold", redirect_pc, 32'h304);

    // ---- full buffer and tag wrap ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      enq(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
      check_val("t5_fill_tag", {29'd0, tag_seen}, 32'(i));
    end
    check_val("t5_count8", {28'd0, count}, 32'd8);
    cyc(1'b0, 1'b1, 32'hDEAD0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
    check_val("t5_full_ready", {31'd0, ready_seen}, 32'd0);
    check_val("t5_no_enq", {28'd0, count}, 32'd8);
    cyc(1'b0, 1'b1, 32'hDEAD4, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
    check_val("t5_no_bypass", {31'd0, ready_seen}, 32'd0);
    exp_upd("t5", 32'h1000, 1'b0, 32'h1004);
    check_val("t5_count7", {28'd0, count}, 32'd7);
    enq(32'h2000, 1'b0, 32'h0);
    check_val("t5_ready_again", {31'd0, ready_seen}, 32'd1);
    check_val("t5_wrap_tag", {29'd0, tag_seen}, 32'd0);
    check_val("t5_count8b", {28'd0, count}, 32'd8);

    // ---- reset mid-operation with pending mispredict ----
    do_reset();
    for (int i = 0; i < 5; i++) enq(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
    res(3'd0, 1'b1, 32'h999);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0);
    check_val("t6_count", {28'd0, count}, 32'd0);
    check_val("t6_flush", {31'd0, flush}, 32'd0);
    check_val("t6_upd", {31'd0, upd_valid}, 32'd0);
    res(3'd2, 1'b0, 32'h0);
    idle();
    check_val("t6_stale_upd", {31'd0, upd_valid}, 32'd0);
    idle();
    check_val("t6_stale_upd2", {31'd0, upd_valid}, 32'd0);
    check_val("t6_count2", {28'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
